dmem_snake_reader: RTL and testbench

Read-side companion to the processor's data-memory writes: on each frame-start pulse from the VGA controller, it scans a fixed block of data-memory words through the VGA-side dmem port. It then publishes them atomically as a packed snake-board snapshot. It sits between the dmem second port (`address_dmem_fromVGA` / `q_dmem_toVGA`) and the VGA renderer (`snake_data`). The renderer never sees a partially updated board.

---
 rtl/dmem_snake_reader_if.sv | 23 ++
 rtl/dmem_snake_reader.sv | 180 ++++++++++++++++++
 tb/tb_dmem_snake_reader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_snake_reader_if.sv
// dmem_snake_reader_if: VGA-side data-memory read port.
// master: the snapshot reader (drives address/data/wren, receives q).
// slave:  the data memory (returns q).
interface dmem_snake_reader_if;
    logic [11:0] address_dmem_fromVGA;
    logic [31:0] data_fromVGA;
    logic        wren_fromVGA;
    logic [31:0] q_dmem_toVGA;

    modport master (
        output address_dmem_fromVGA,
        output data_fromVGA,
        output wren_fromVGA,
        input  q_dmem_toVGA
    );

    modport slave (
        input  address_dmem_fromVGA,
        input  data_fromVGA,
        input  wren_fromVGA,
        output q_dmem_toVGA
    );
endinterface

// File: rtl/dmem_snake_reader.sv
// dmem_snake_reader: on each frame_start, scans NUM_WORDS data-memory words starting at
// BASE_ADDR into a shadow buffer, then commits them to snake_data in a single cycle so the
// renderer never sees a partially updated board.
// Optional feature: define DMEM_SNAKE_READER_XOR_EN to build the frame_xor checksum;
// otherwise frame_xor is tied to zero.
module dmem_snake_reader #(
    parameter logic [11:0] BASE_ADDR = 12'd0,
    parameter int unsigned NUM_WORDS = 10,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    frame_start,
    dmem_snake_reader_if.master     dmem,
    output logic [NUM_WORDS*32-1:0] snake_data,
    output logic                    snapshot_valid,
    output logic                    busy,
    output logic [31:0]             frame_xor
);

    // 7 bits: the capture counter reaches NUM_WORDS (up to 64) after the last capture.
    localparam int unsigned CntW = 7;
    localparam logic [CntW-1:0] LastIdx   = CntW'(NUM_WORDS - 1);
    localparam logic [1:0]      LastDrain = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StCommit} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         issue_q, issue_d;
    logic [CntW-1:0]         cap_q;
    logic [1:0]              drain_q, drain_d;
    logic                    pending_q, pending_d;
    logic [RD_LAT-1:0]       cap_pipe_q;
    logic [NUM_WORDS*32-1:0] shadow_q;
    logic                    start_scan;
    logic                    commit;
    logic                    issuing;
    logic                    cap_en;

    assign issuing = (state_q == StRead);
    assign cap_en  = cap_pipe_q[RD_LAT-1];
    assign busy    = (state_q != StIdle);

    assign dmem.data_fromVGA = '0;
    assign dmem.wren_fromVGA = 1'b0;

    // Read address: walks BASE_ADDR+i (mod 4096) during READ, parks at BASE_ADDR otherwise.
    always_comb begin
        dmem.address_dmem_fromVGA = BASE_ADDR;
        if (issuing) begin
            dmem.address_dmem_fromVGA = BASE_ADDR + 12'(issue_q);
        end
    end

    // Next-state logic for the scan FSM and the pending-request flag.
    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        drain_d    = drain_q;
        pending_d  = pending_q;
        start_scan = 1'b0;
        commit     = 1'b0;
        if (frame_start && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d    = StRead;
                    start_scan = 1'b1;
                end
            end
            StRead: begin
                issue_d = issue_q + CntW'(1);
                drain_d = '0;
                if (issue_q == LastIdx) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == LastDrain) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit = 1'b1;
                // A request arriving in this very cycle is served by the restart too.
                if (pending_q || frame_start) begin
                    state_d    = StRead;
                    start_scan = 1'b1;
                    pending_d  = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (start_scan) begin
            issue_d = '0;
        end
    end

    // FSM state, issue/drain counters and pending flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            issue_q   <= '0;
            drain_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            drain_q   <= drain_d;
            pending_q <= pending_d;
        end
    end

    // Capture pipeline: an issue in cycle c becomes a capture enable in cycle c+RD_LAT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_pipe_q <= '0;
        end else begin
            cap_pipe_q[0] <= issuing;
            for (int j = 1; j < RD_LAT; j++) begin
                cap_pipe_q[j] <= cap_pipe_q[j-1];
            end
        end
    end

    // Shadow buffer fill: returning words land in consecutive slots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_q    <= '0;
            shadow_q <= '0;
        end else if (start_scan) begin
            cap_q <= '0;
        end else if (cap_en) begin
            shadow_q[32*int'(cap_q) +: 32] <= dmem.q_dmem_toVGA;
            cap_q                          <= cap_q + CntW'(1);
        end
    end

    // Atomic publish of the shadow buffer with a one-cycle valid pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snake_data     <= '0;
            snapshot_valid <= 1'b0;
        end else begin
            snapshot_valid <= commit;
            if (commit) begin
                snake_data <= shadow_q;
            end
        end
    end

`ifdef DMEM_SNAKE_READER_XOR_EN
    logic [31:0] xor_acc_q;

    // Running XOR of captured words, published alongside snake_data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xor_acc_q <= '0;
            frame_xor <= '0;
        end else begin
            if (start_scan) begin
                xor_acc_q <= '0;
            end else if (cap_en) begin
                xor_acc_q <= xor_acc_q ^ dmem.q_dmem_toVGA;
            end
            if (commit) begin
                frame_xor <= xor_acc_q;
            end
        end
    end
`else
    assign frame_xor = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_snake_reader.sv
// Directed bench for dmem_snake_reader: three instances (defaults, wrapped base address,
// two-cycle read latency), each with its own data-memory model.
module tb_dmem_snake_reader;
    localparam int unsigned N = 10;

`ifdef DMEM_SNAKE_READER_XOR_EN
    localparam logic [31:0] XorExp = 32'h0000_03FF;
`else
    localparam logic [31:0] XorExp = 32'h0000_0000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic fs0 = 1'b0;
    logic fs1 = 1'b0;
    logic fs2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_snake_reader_if dm0 ();
    dmem_snake_reader_if dm1 ();
    dmem_snake_reader_if dm2 ();

    logic [N*32-1:0] sd0, sd1, sd2;
    logic            v0, v1, v2;
    logic            b0, b1, b2;
    logic [31:0]     x0, x1, x2;

    logic [31:0] mem0 [4096];
    logic [31:0] mem1 [4096];
    logic [31:0] mem2 [4096];
    logic [31:0] rd0, rd1, rd2a, rd2;

    // Memory models: one-cycle for dm0/dm1, two-cycle for dm2.
    always @(posedge clock) begin
        rd0  <= mem0[dm0.address_dmem_fromVGA];
        rd1  <= mem1[dm1.address_dmem_fromVGA];
        rd2a <= mem2[dm2.address_dmem_fromVGA];
        rd2  <= rd2a;
    end

    assign dm0.q_dmem_toVGA = rd0;
    assign dm1.q_dmem_toVGA = rd1;
    assign dm2.q_dmem_toVGA = rd2;

    dmem_snake_reader #(.BASE_ADDR(12'd0), .NUM_WORDS(N), .RD_LAT(1)) dut0 (
        .clock(clock), .reset(reset), .frame_start(fs0), .dmem(dm0.master),
        .snake_data(sd0), .snapshot_valid(v0), .busy(b0), .frame_xor(x0)
    );

    dmem_snake_reader #(.BASE_ADDR(12'hFFC), .NUM_WORDS(N), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .frame_start(fs1), .dmem(dm1.master),
        .snake_data(sd1), .snapshot_valid(v1), .busy(b1), .frame_xor(x1)
    );

    dmem_snake_reader #(.BASE_ADDR(12'd0), .NUM_WORDS(N), .RD_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .frame_start(fs2), .dmem(dm2.master),
        .snake_data(sd2), .snapshot_valid(v2), .busy(b2), .frame_xor(x2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [11:0] wa;
        logic [11:0] ea;
        logic [31:0] ew;

        for (int a = 0; a < 4096; a++) begin
            mem0[a] = '0;
            mem1[a] = '0;
            mem2[a] = '0;
        end
        for (int j = 0; j < int'(N); j++) begin
            mem0[j]  = 32'h100 + 32'(j);
            wa       = 12'hFFC + 12'(j);
            mem1[wa] = 32'h200 + 32'(j);
            mem2[j]  = 32'h1 << j;
        end

        // Reset state
        reset = 1'b1;
        cyc();
        cyc();
        check("rst busy0", 32'(b0), 32'd0);
        check("rst valid0", 32'(v0), 32'd0);
        check("rst addr0", 32'(dm0.address_dmem_fromVGA), 32'h000);
        check("rst addr1", 32'(dm1.address_dmem_fromVGA), 32'hFFC);
        check("rst snake0", sd0[31:0], 32'd0);
        check("rst xor2", x2, 32'd0);
        reset = 1'b0;
        cyc();

        // Basic scan, wrapped base and two-cycle latency, all launched at the same edge E0
        fs0 = 1'b1;
        fs1 = 1'b1;
        fs2 = 1'b1;
        cyc();
        fs0 = 1'b0;
        fs1 = 1'b0;
        fs2 = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            ea = (c < int'(N)) ? 12'hFFC + 12'(c) : 12'hFFC;
            check($sformatf("busy0 c%0d", c), 32'(b0), 32'(c < 12));
            check($sformatf("valid0 c%0d", c), 32'(v0), 32'(c == 12));
            check($sformatf("addr0 c%0d", c), 32'(dm0.address_dmem_fromVGA),
                  32'((c < int'(N)) ? c : 0));
            check($sformatf("valid1 c%0d", c), 32'(v1), 32'(c == 12));
            check($sformatf("addr1 c%0d", c), 32'(dm1.address_dmem_fromVGA), 32'(ea));
            check($sformatf("busy2 c%0d", c), 32'(b2), 32'(c < 13));
            check($sformatf("valid2 c%0d", c), 32'(v2), 32'(c == 13));
            check($sformatf("wren2 c%0d", c), 32'(dm2.wren_fromVGA), 32'd0);
            check($sformatf("data2 c%0d", c), dm2.data_fromVGA, 32'd0);
            if (c == 13) begin
                check("xor2 on pulse", x2, XorExp);
            end
            cyc();
        end
        for (int j = 0; j < int'(N); j++) begin
            check($sformatf("basic word%0d", j), sd0[32*j +: 32], 32'h100 + 32'(j));
            check($sformatf("wrap word%0d", j), sd1[32*j +: 32], 32'h200 + 32'(j));
            check($sformatf("lat2 word%0d", j), sd2[32*j +: 32], 32'h1 << j);
        end

        // Atomicity and pending: extra request at c5 with dmem rewritten, then three
        // requests during the second scan giving exactly one more scan.
        fs0 = 1'b1;
        cyc();
        for (int c = 0; c <= 40; c++) begin
            fs0 = (c == 5) || (c == 14) || (c == 16) || (c == 18);
            if (c == 5) begin
                for (int j = 0; j < int'(N); j++) begin
                    mem0[j] = 32'h300 + 32'(j);
                end
            end
            check($sformatf("pend busy c%0d", c), 32'(b0), 32'(c < 36));
            check($sformatf("pend valid c%0d", c), 32'(v0),
                  32'((c == 12) || (c == 24) || (c == 36)));
            if (c == 11) begin
                check("atomic word9 before commit", sd0[32*9 +: 32], 32'h109);
                check("atomic word0 before commit", sd0[31:0], 32'h100);
            end
            if (c == 12) begin
                for (int j = 0; j < int'(N); j++) begin
                    ew = (j < 5) ? 32'h100 + 32'(j) : 32'h300 + 32'(j);
                    check($sformatf("commit1 word%0d", j), sd0[32*j +: 32], ew);
                end
            end
            if (c == 23) begin
                check("atomic word0 mid scan2", sd0[31:0], 32'h100);
            end
            if (c == 24) begin
                for (int j = 0; j < int'(N); j++) begin
                    check($sformatf("commit2 word%0d", j), sd0[32*j +: 32],
                          32'h300 + 32'(j));
                end
            end
            cyc();
        end
        fs0 = 1'b0;

        // Reset mid-scan
        fs0 = 1'b1;
        cyc();
        fs0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
        end
        reset = 1'b1;
        #1;
        check("midrst busy0", 32'(b0), 32'd0);
        check("midrst valid0", 32'(v0), 32'd0);
        check("midrst addr0", 32'(dm0.address_dmem_fromVGA), 32'h000);
        check("midrst xor0", x0, 32'd0);
        for (int j = 0; j < int'(N); j++) begin
            check($sformatf("midrst word%0d", j), sd0[32*j +: 32], 32'd0);
        end
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 14; c++) begin
            check($sformatf("postrst valid c%0d", c), 32'(v0), 32'd0);
            check($sformatf("postrst busy c%0d", c), 32'(b0), 32'd0);
            cyc();
        end

        // Fresh scan after reset
        fs0 = 1'b1;
        cyc();
        fs0 = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            check($sformatf("fresh busy c%0d", c), 32'(b0), 32'(c < 12));
            check($sformatf("fresh valid c%0d", c), 32'(v0), 32'(c == 12));
            cyc();
        end
        for (int j = 0; j < int'(N); j++) begin
            check($sformatf("fresh word%0d", j), sd0[32*j +: 32], 32'h300 + 32'(j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
